// File: rtl/execution_module.sv
// EX stage of a MIPS-style pipeline: the ALU, the branch-target adder and the
// destination mux, all captured in the EX/MEM register with one cycle of latency.
module execution_module (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegDst,
    input  logic        ALUOp1,
    input  logic        ALUOp2,
    input  logic        ALUSrc,
    input  logic [31:0] fromIFstage,
    input  logic [31:0] sign_extended,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    input  logic [4:0]  inst_20_16,
    input  logic [4:0]  inst_15_11,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        Branch,
    output logic [31:0] add_result,
    output logic [31:0] alu_result,
    output logic [31:0] read_data2_out,
    output logic [4:0]  mux_out,
    output logic        zero_out,
    output logic        MemtoReg_out,
    output logic        RegWrite_out,
    output logic        MemRead_out,
    output logic        MemWrite_out,
    output logic        Branch_out
);

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // Add/sub wrap modulo 2^32; SLT variants return 1/0; unknown funct gives 0.
    function automatic logic signed [DATA_W-1:0] alu_fn(
        input logic [1:0]               op,
        input logic [5:0]               funct,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [DATA_W-1:0] r;
        r = '0;
        case (op)
            2'b00, 2'b11: r = a + b;
            2'b01:        r = a - b;
            default: begin
                case (funct)
                    6'h20, 6'h21: r = a + b;
                    6'h22, 6'h23: r = a - b;
                    6'h24:        r = a & b;
                    6'h25:        r = a | b;
                    6'h26:        r = a ^ b;
                    6'h27:        r = ~(a | b);
                    6'h2A:        r = (a < b) ? DATA_W'(1) : '0;
                    6'h2B:        r = ($unsigned(a) < $unsigned(b)) ? DATA_W'(1) : '0;
                    default:      r = '0;
                endcase
            end
        endcase
        return r;
    endfunction

    logic signed [DATA_W-1:0] op_a;
    logic signed [DATA_W-1:0] op_b;
    logic signed [DATA_W-1:0] alu_val;
    logic        [DATA_W-1:0] target_val;
    logic        [REG_W-1:0]  dest_val;

    always_comb begin
        op_a       = read_data1;
        op_b       = ALUSrc ? sign_extended : read_data2;
        alu_val    = alu_fn({ALUOp1, ALUOp2}, sign_extended[5:0], op_a, op_b);
        target_val = fromIFstage + (sign_extended << 2);
        dest_val   = RegDst ? inst_15_11 : inst_20_16;
    end

    logic signed [DATA_W-1:0] alu_result_p1;
    logic        [DATA_W-1:0] add_result_p1;
    logic        [DATA_W-1:0] read_data2_p1;
    logic        [REG_W-1:0]  mux_p1;
    logic                     zero_p1;
    logic        [4:0]        ctrl_p1;

    // EX/MEM boundary: reset clears data as well as control so nothing stale leaks out.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_p1 <= '0;
            add_result_p1 <= '0;
            read_data2_p1 <= '0;
            mux_p1        <= '0;
            zero_p1       <= 1'b0;
            ctrl_p1       <= '0;
        end else begin
            alu_result_p1 <= alu_val;
            add_result_p1 <= target_val;
            read_data2_p1 <= read_data2;
            mux_p1        <= dest_val;
            zero_p1       <= (alu_val == '0);
            ctrl_p1       <= {MemtoReg, RegWrite, MemRead, MemWrite, Branch};
        end
    end

    assign alu_result     = alu_result_p1;
    assign add_result     = add_result_p1;
    assign read_data2_out = read_data2_p1;
    assign mux_out        = mux_p1;
    assign zero_out       = zero_p1;
    assign MemtoReg_out   = ctrl_p1[4];
    assign RegWrite_out   = ctrl_p1[3];
    assign MemRead_out    = ctrl_p1[2];
    assign MemWrite_out   = ctrl_p1[1];
    assign Branch_out     = ctrl_p1[0];

endmodule

// File: tb/tb_execution_module.sv
// Scoreboard bench for execution_module: the driver pushes reference-model
// results, the monitor pops and compares one entry after every rising edge.
module tb_execution_module;

    typedef struct {
        logic        rst;
        logic        regdst;
        logic [1:0]  aluop;
        logic        alusrc;
        logic [31:0] pc;
        logic [31:0] sext;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  ctrl;
    } stim_t;

    typedef struct {
        logic [31:0] add;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  mux;
        logic        zero;
        logic [4:0]  ctrl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RegDst = 1'b0, ALUOp1 = 1'b0, ALUOp2 = 1'b0, ALUSrc = 1'b0;
    logic [31:0] fromIFstage = '0, sign_extended = '0, read_data1 = '0, read_data2 = '0;
    logic [4:0]  inst_20_16 = '0, inst_15_11 = '0;
    logic        MemtoReg = 1'b0, RegWrite = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, Branch = 1'b0;
    logic [31:0] add_result, alu_result, read_data2_out;
    logic [4:0]  mux_out;
    logic        zero_out, MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    execution_module dut (
        .clk(clk), .rst(rst), .RegDst(RegDst), .ALUOp1(ALUOp1), .ALUOp2(ALUOp2),
        .ALUSrc(ALUSrc), .fromIFstage(fromIFstage), .sign_extended(sign_extended),
        .read_data1(read_data1), .read_data2(read_data2),
        .inst_20_16(inst_20_16), .inst_15_11(inst_15_11),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .Branch(Branch),
        .add_result(add_result), .alu_result(alu_result), .read_data2_out(read_data2_out),
        .mux_out(mux_out), .zero_out(zero_out),
        .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out), .MemRead_out(MemRead_out),
        .MemWrite_out(MemWrite_out), .Branch_out(Branch_out)
    );

    // Reference: what the EX/MEM register should hold after the edge that samples s.
    function automatic exp_t model(input stim_t s);
        exp_t e;
        longint unsigned a, b, r;
        e = '{add: '0, alu: '0, rd2: '0, mux: '0, zero: 1'b0, ctrl: '0};
        if (s.rst) return e;
        a = s.rd1;
        b = s.alusrc ? s.sext : s.rd2;
        r = 0;
        if (s.aluop == 2'b00 || s.aluop == 2'b11)      r = (a + b) % 64'h1_0000_0000;
        else if (s.aluop == 2'b01)                     r = (a + 64'h1_0000_0000 - b) % 64'h1_0000_0000;
        else begin
            case (s.sext[5:0])
                6'h20, 6'h21: r = (a + b) % 64'h1_0000_0000;
                6'h22, 6'h23: r = (a + 64'h1_0000_0000 - b) % 64'h1_0000_0000;
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = 64'hFFFF_FFFF - (a | b);
                6'h2A: r = ($signed(32'(a)) < $signed(32'(b))) ? 1 : 0;
                6'h2B: r = (a < b) ? 1 : 0;
                default: r = 0;
            endcase
        end
        e.alu  = 32'(r);
        e.zero = (r == 0);
        e.add  = 32'((64'(s.pc) + 64'(s.sext) * 4) % 64'h1_0000_0000);
        e.rd2  = s.rd2;
        e.mux  = s.regdst ? s.rd : s.rt;
        e.ctrl = s.ctrl;
        return e;
    endfunction

    task automatic drive(input stim_t s);
        @(negedge clk);
        rst = s.rst; RegDst = s.regdst; ALUOp1 = s.aluop[1]; ALUOp2 = s.aluop[0];
        ALUSrc = s.alusrc; fromIFstage = s.pc; sign_extended = s.sext;
        read_data1 = s.rd1; read_data2 = s.rd2; inst_20_16 = s.rt; inst_15_11 = s.rd;
        {MemtoReg, RegWrite, MemRead, MemWrite, Branch} = s.ctrl;
        sb.push_back(model(s));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: outputs settle one time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("alu_result", alu_result, e.alu);
                chk("add_result", add_result, e.add);
                chk("read_data2_out", read_data2_out, e.rd2);
                chk("mux_out", 32'(mux_out), 32'(e.mux));
                chk("zero_out", 32'(zero_out), 32'(e.zero));
                chk("ctrl_out", 32'({MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out}),
                    32'(e.ctrl));
            end
        end
    end

    initial begin
        stim_t s;
        stim_t z;
        logic [5:0] functs [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                    6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h3F};
        logic [5:0] sweep [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2B};
        logic [31:0] tmp;
        z = '{rst: 1'b0, regdst: 1'b0, aluop: 2'b00, alusrc: 1'b0, pc: '0, sext: '0,
              rd1: '0, rd2: '0, rt: '0, rd: '0, ctrl: '0};

        // Reset with non-zero inputs present: everything must still clear.
        s = z; s.rst = 1'b1; s.rd1 = 32'h1234; s.rd2 = 32'h55; s.rt = 5'd9; s.ctrl = 5'h1F; s.pc = 32'h40;
        drive(s);

        s = z; s.aluop = 2'b01; s.rd1 = 1; s.rd2 = 1; s.rt = 3; s.sext = 32'h20;
        drive(s);
        s = z; s.aluop = 2'b01; s.regdst = 1'b1; s.rd1 = 7; s.rd2 = 2; s.rd = 5'h10; s.sext = 32'h22;
        drive(s);
        foreach (sweep[i]) begin
            s = z; s.aluop = 2'b10; s.rd1 = 32'hFFFF_FFFF; s.rd2 = 1; s.sext = 32'(sweep[i]);
            drive(s);
        end
        s = z; s.alusrc = 1'b1; s.rd1 = 32'h100; s.sext = 32'hFFFF_FFFC; s.pc = 32'h40;
        drive(s);
        s = z; s.ctrl = 5'h1F; s.rd2 = 32'hDEAD_BEEF;
        drive(s);
        s.rst = 1'b1;
        drive(s);

        for (int n = 0; n < 400; n++) begin
            s = z;
            s.rst    = ($urandom_range(0, 24) == 0);
            s.regdst = 1'($urandom_range(0, 1));
            s.aluop  = 2'($urandom_range(0, 3));
            s.alusrc = 1'($urandom_range(0, 1));
            s.pc     = $urandom();
            tmp      = $urandom();
            s.sext   = (tmp & 32'hFFFF_FFC0) | 32'(functs[$urandom_range(0, 11)]);
            if ($urandom_range(0, 3) == 0) s.sext = {{16{tmp[15]}}, tmp[15:0]};
            s.rd1    = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom();
            s.rd2    = ($urandom_range(0, 5) == 0) ? s.rd1 : $urandom();
            s.rt     = 5'($urandom());
            s.rd     = 5'($urandom());
            s.ctrl   = 5'($urandom());
            drive(s);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
